// File: rtl/crc_seq_neuron.sv
// Sequential neuron: streams CRC-protected weights, refetches bad words, and accumulates
// X[i]*W[i] in a triplicated, majority-voted accumulator. Output is saturated and optionally ReLU'd.
`timescale 1ns/1ps
module crc_seq_neuron #(
    parameter int            M         = 8,
    parameter int            n         = 16,
    parameter int            cl        = 8,
    parameter int            intbits   = 6,
    parameter int            fracbits  = 10,
    parameter logic [cl-1:0] POLY      = 8'h07,
    parameter int            MAX_RETRY = 3,
    parameter bit            RELU      = 1'b1,
    localparam int           IW        = (M > 1) ? $clog2(M) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [M*n-1:0]  X,
    input  logic            w_valid,
    input  logic [n+cl-1:0] w_data,
    output logic            w_ready,
    output logic [IW-1:0]   w_idx,
    output logic            rf_req,
    input  logic [2:0]      tmr_inj,
    output logic            busy,
    output logic            out_valid,
    output logic [n-1:0]    H,
    output logic            err
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | accepting weights, one per handshake
    // RFQ   | bad CRC seen: refetch requested, weight port closed for one cycle
    // OUT   | present H/err for one cycle
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RFQ, S_OUT} state_t;

    localparam int AW = 2*n + IW;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    // Binary point position; falls back to n-intbits if the two format parameters disagree.
    localparam int FB = (intbits + fracbits == n) ? fracbits : n - intbits;
    localparam logic signed [AW-1:0] HMAX = {{(AW-n+1){1'b0}}, {(n-1){1'b1}}};
    localparam logic signed [AW-1:0] HMIN = {{(AW-n+1){1'b1}}, {(n-1){1'b0}}};

    state_t                 state;
    logic signed [n-1:0]    x_q [M];
    logic signed [AW-1:0]   acc [3];
    logic [RW-1:0]          retry;
    logic                   err_q;

    logic signed [AW-1:0]   c0, c1, c2, voted, upd, acc_nxt;
    logic signed [n-1:0]    w_sgn, x_sel, h_sat;
    logic signed [2*n-1:0]  prod, prod_sh;
    logic                   crc_ok, accept;

    function automatic logic [cl-1:0] crc_calc(input logic [n-1:0] d);
        logic [cl-1:0] c;
        logic          fb;
        c = '0;
        for (int i = n-1; i >= 0; i--) begin
            fb = c[cl-1] ^ d[i];
            c  = {c[cl-2:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    always_comb begin
        c0      = acc[0] ^ {{(AW-1){1'b0}}, tmr_inj[0]};
        c1      = acc[1] ^ {{(AW-1){1'b0}}, tmr_inj[1]};
        c2      = acc[2] ^ {{(AW-1){1'b0}}, tmr_inj[2]};
        voted   = (c0 & c1) | (c0 & c2) | (c1 & c2);
        w_sgn   = w_data[n+cl-1:cl];
        crc_ok  = (crc_calc(w_data[n+cl-1:cl]) == w_data[cl-1:0]);
        x_sel   = x_q[w_idx];
        prod    = x_sel * w_sgn;
        prod_sh = prod >>> FB;
        upd     = {{IW{prod_sh[2*n-1]}}, prod_sh};
        accept  = (state == S_RUN) && w_valid && crc_ok;
        acc_nxt = voted + (accept ? upd : '0);
        if (voted > HMAX)      h_sat = HMAX[n-1:0];
        else if (voted < HMIN) h_sat = HMIN[n-1:0];
        else                   h_sat = voted[n-1:0];
        if (RELU && h_sat[n-1]) h_sat = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            w_ready   <= 1'b0;
            w_idx     <= '0;
            rf_req    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            H         <= '0;
            err       <= 1'b0;
            err_q     <= 1'b0;
            retry     <= '0;
            for (int k = 0; k < 3; k++) acc[k] <= '0;
            for (int i = 0; i < M; i++) x_q[i] <= '0;
        end else begin
            rf_req    <= 1'b0;
            out_valid <= 1'b0;
            // Every copy is rewritten from the vote each cycle, scrubbing single-copy upsets.
            for (int k = 0; k < 3; k++) acc[k] <= acc_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < M; i++) x_q[i] <= X[i*n +: n];
                        for (int k = 0; k < 3; k++) acc[k] <= '0;
                        w_idx   <= '0;
                        retry   <= '0;
                        err_q   <= 1'b0;
                        busy    <= 1'b1;
                        w_ready <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_valid) begin
                        if (crc_ok) begin
                            retry <= '0;
                            if (w_idx == IW'(M-1)) begin
                                w_idx   <= '0;
                                w_ready <= 1'b0;
                                state   <= S_OUT;
                            end else begin
                                w_idx <= w_idx + 1'b1;
                            end
                        end else begin
                            w_ready <= 1'b0;
                            if (retry < RW'(MAX_RETRY)) begin
                                rf_req <= 1'b1;
                                retry  <= retry + 1'b1;
                                state  <= S_RFQ;
                            end else begin
                                err_q <= 1'b1;
                                state <= S_OUT;
                            end
                        end
                    end
                end
                S_RFQ: begin
                    w_ready <= 1'b1;
                    state   <= S_RUN;
                end
                S_OUT: begin
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    H         <= err_q ? '0 : h_sat;
                    err       <= err_q;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_seq_neuron.sv
// Bench for crc_seq_neuron: a weight source with injectable CRC faults and stalls drives two
// instances (ReLU and linear) and results are compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_crc_seq_neuron;
    localparam int M = 8, N = 16, CL = 8, MAXR = 3;

    logic            clk = 1'b0;
    logic            rst_n, start, w_valid;
    logic [M*N-1:0]  x;
    logic [N+CL-1:0] w_data;
    logic [2:0]      tmr_inj;
    logic            w_ready, rf_req, busy, out_valid, err;
    logic [2:0]      w_idx;
    logic [N-1:0]    h;
    logic            w_ready_l, rf_req_l, busy_l, out_valid_l, err_l;
    logic [2:0]      w_idx_l;
    logic [N-1:0]    h_l;

    crc_seq_neuron #(.RELU(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .X(x), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready), .w_idx(w_idx), .rf_req(rf_req), .tmr_inj(tmr_inj), .busy(busy),
        .out_valid(out_valid), .H(h), .err(err));

    crc_seq_neuron #(.RELU(1'b0)) dut_lin (
        .clk(clk), .rst_n(rst_n), .start(start), .X(x), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready_l), .w_idx(w_idx_l), .rf_req(rf_req_l), .tmr_inj(tmr_inj), .busy(busy_l),
        .out_valid(out_valid_l), .H(h_l), .err(err_l));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // scenario inputs
    logic [N-1:0] xv [M];
    logic [N-1:0] wv [M];
    int           bad_cnt [M];
    int           stall_pct, inj_cycle, abort_idx;
    logic [2:0]   inj_val;
    // scenario observations
    logic [N-1:0] obs_h, obs_hl, h_after;
    logic         obs_err, obs_err_l, obs_busy, ov_after;
    int           obs_lat, obs_rf, idx_err;
    bit           timed_out, aborted;

    // CRC as remainder of W(x)*x^8 divided by x^8+x^2+x+1
    function automatic logic [CL-1:0] crc_ref(input logic [N-1:0] w);
        logic [N+CL-1:0] r;
        r = {w, {CL{1'b0}}};
        for (int b = N+CL-1; b >= CL; b--)
            if (r[b]) r[b -: CL+1] = r[b -: CL+1] ^ 9'h107;
        return r[CL-1:0];
    endfunction

    function automatic logic [N-1:0] model_h(input bit relu);
        longint s = 0;
        for (int i = 0; i < M; i++) begin
            if (bad_cnt[i] > MAXR) return '0;
            s += (longint'($signed(xv[i])) * longint'($signed(wv[i]))) >>> 10;
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return N'(s);
    endfunction

    function automatic bit model_err();
        for (int i = 0; i < M; i++) if (bad_cnt[i] > MAXR) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_rf();
        int r = 0;
        for (int i = 0; i < M; i++) begin
            if (bad_cnt[i] > MAXR) return r + MAXR;
            r += bad_cnt[i];
        end
        return r;
    endfunction

    task automatic set_defaults();
        for (int i = 0; i < M; i++) begin
            xv[i] = 16'h0400; wv[i] = 16'h0400; bad_cnt[i] = 0;
        end
        stall_pct = 0; inj_cycle = -1; inj_val = 3'b000; abort_idx = -1;
    endtask

    // Drives one neuron evaluation; inputs change and outputs are sampled on the falling edge.
    task automatic run_neuron();
        int  src, cyc, si;
        int  bads [M];
        bit  hs, sent_bad, done;
        for (int i = 0; i < M; i++) begin
            bads[i] = bad_cnt[i];
            x[i*N +: N] = xv[i];
        end
        obs_rf = 0; idx_err = 0; timed_out = 0; aborted = 0; done = 0;
        src = 0; hs = 0; sent_bad = 0; cyc = 0;
        @(negedge clk); start = 1'b1; w_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        while (!done && cyc < 300) begin
            if (hs) begin
                if (sent_bad) bads[src]--;
                else src++;
            end
            if (rf_req) begin
                obs_rf++;
                if (int'(w_idx) != src) idx_err++;
            end
            if (out_valid) begin
                obs_h = h; obs_hl = h_l; obs_err = err; obs_err_l = err_l;
                obs_busy = busy; obs_lat = cyc; done = 1;
            end
            if (!done && abort_idx >= 0 && busy && int'(w_idx) == abort_idx) begin
                rst_n = 1'b0; w_valid = 1'b0;
                #1 aborted = 1;
                return;
            end
            if (!done && w_ready && src < M && int'(w_idx) != src) idx_err++;
            tmr_inj = (cyc == inj_cycle) ? inj_val : 3'b000;
            si = (src < M) ? src : 0;
            sent_bad = (src < M) && (bads[si] > 0);
            w_valid = !done && (src < M) && ($urandom_range(99) >= stall_pct);
            w_data = {wv[si], crc_ref(wv[si]) ^ {7'd0, sent_bad}};
            hs = w_valid && w_ready;
            @(negedge clk); cyc++;
        end
        w_valid = 1'b0; tmr_inj = 3'b000;
        if (!done) begin
            timed_out = 1;
            return;
        end
        ov_after = out_valid; h_after = h;
    endtask

    task automatic check_done(input string name);
        vectors++;
        if (timed_out) begin
            miscompares++;
            $display("FAIL %s: out_valid timeout, got none, need one within 300 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; w_valid = 1'b0; w_data = '0; x = '0; tmr_inj = 3'b000;
        repeat (3) @(negedge clk);
        vectors++;
        if ({w_ready, w_idx, rf_req, busy, out_valid, h, err,
             w_ready_l, w_idx_l, rf_req_l, busy_l, out_valid_l, h_l, err_l} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got h=%h err=%b busy=%b w_ready=%b idx=%0d, need all 0",
                     h, err, busy, w_ready, w_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_defaults();
        run_neuron();
        check_done("basic");
        vectors++;
        if (obs_h !== 16'h2000 || obs_err !== 1'b0) begin
            miscompares++; $display("FAIL basic_h: got h=%h err=%b, need 2000/0", obs_h, obs_err);
        end
        vectors++;
        if (obs_lat !== M+1) begin
            miscompares++; $display("FAIL basic_latency: got %0d, need %0d", obs_lat, M+1);
        end
        vectors++;
        if (obs_rf !== 0 || obs_busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_rf_busy: got rf=%0d busy=%b, need 0/0", obs_rf, obs_busy);
        end
        vectors++;
        if (ov_after !== 1'b0 || h_after !== 16'h2000) begin
            miscompares++;
            $display("FAIL basic_hold: got out_valid=%b h=%h after pulse, need 0/2000", ov_after, h_after);
        end
    endtask

    task automatic test_retry_once();
        set_defaults();
        bad_cnt[7] = 1;
        run_neuron();
        check_done("retry_once");
        vectors++;
        if (obs_h !== 16'h2000 || obs_err !== 1'b0 || obs_lat !== M+3) begin
            miscompares++;
            $display("FAIL retry_once: got h=%h err=%b lat=%0d, need 2000/0/%0d", obs_h, obs_err, obs_lat, M+3);
        end
        vectors++;
        if (obs_rf !== 1 || idx_err !== 0) begin
            miscompares++; $display("FAIL retry_once_rf: got rf=%0d idx_err=%0d, need 1/0", obs_rf, idx_err);
        end
    endtask

    task automatic test_retry_limit();
        set_defaults();
        bad_cnt[3] = 4;
        run_neuron();
        check_done("retry_limit");
        vectors++;
        if (obs_rf !== 3 || obs_err !== 1'b1 || obs_h !== 16'h0000 || obs_err_l !== 1'b1 || obs_hl !== 16'h0000) begin
            miscompares++;
            $display("FAIL retry_limit: got rf=%0d err=%b h=%h h_lin=%h, need 3/1/0000/0000",
                     obs_rf, obs_err, obs_h, obs_hl);
        end
    endtask

    task automatic test_saturation();
        set_defaults();
        for (int i = 0; i < M; i++) xv[i] = 16'h7FFF;
        run_neuron();
        check_done("sat_pos");
        vectors++;
        if (obs_h !== 16'h7FFF || obs_hl !== 16'h7FFF) begin
            miscompares++; $display("FAIL sat_pos: got h=%h h_lin=%h, need 7fff/7fff", obs_h, obs_hl);
        end
        for (int i = 0; i < M; i++) xv[i] = 16'h8000;
        run_neuron();
        check_done("sat_neg");
        vectors++;
        if (obs_h !== 16'h0000 || obs_hl !== 16'h8000) begin
            miscompares++; $display("FAIL sat_neg: got h=%h h_lin=%h, need 0000/8000", obs_h, obs_hl);
        end
    endtask

    task automatic test_tmr();
        set_defaults();
        inj_cycle = 4; inj_val = 3'b010;
        run_neuron();
        check_done("tmr_single");
        vectors++;
        if (obs_h !== 16'h2000) begin
            miscompares++; $display("FAIL tmr_single: got h=%h, need 2000", obs_h);
        end
        inj_val = 3'b011;
        run_neuron();
        check_done("tmr_double");
        vectors++;
        if (obs_h === 16'h2000) begin
            miscompares++; $display("FAIL tmr_double: got h=%h, need a value other than 2000", obs_h);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_ov = 0;
        set_defaults();
        abort_idx = 4;
        run_neuron();
        vectors++;
        if (!aborted || {w_ready, w_idx, rf_req, busy, out_valid, h, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got aborted=%b h=%h busy=%b w_ready=%b idx=%0d, need 1 and all 0",
                     aborted, h, busy, w_ready, w_idx);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || busy) seen_ov = 1;
        end
        vectors++;
        if (seen_ov) begin
            miscompares++; $display("FAIL reset_mid_quiet: got out_valid/busy after reset, need none");
        end
        set_defaults();
        run_neuron();
        check_done("reset_mid_rerun");
        vectors++;
        if (obs_h !== 16'h2000 || obs_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_rerun: got h=%h err=%b, need 2000/0", obs_h, obs_err);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] eh, ehl;
        for (int t = 0; t < 24; t++) begin
            set_defaults();
            stall_pct = 30;
            for (int i = 0; i < M; i++) begin
                if (t % 2 == 0) begin
                    xv[i] = N'($urandom_range(0, 16'h1000)) - 16'h0800;
                    wv[i] = N'($urandom_range(0, 16'h1000)) - 16'h0800;
                end else begin
                    xv[i] = N'($urandom); wv[i] = N'($urandom);
                end
                bad_cnt[i] = ($urandom_range(99) < 15) ? int'($urandom_range(1, 2)) : 0;
            end
            if (t % 6 == 5) bad_cnt[$urandom_range(M-1)] = MAXR + 1;
            eh = model_h(1'b1); ehl = model_h(1'b0);
            run_neuron();
            check_done("random");
            vectors++;
            if (obs_h !== eh || obs_hl !== ehl || obs_err !== model_err() || obs_err_l !== model_err()) begin
                miscompares++;
                $display("FAIL random_%0d: got h=%h h_lin=%h err=%b, need %h/%h/%b",
                         t, obs_h, obs_hl, obs_err, eh, ehl, model_err());
            end
            vectors++;
            if (obs_rf !== model_rf() || idx_err !== 0) begin
                miscompares++;
                $display("FAIL random_rf_%0d: got rf=%0d idx_err=%0d, need %0d/0", t, obs_rf, idx_err, model_rf());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_retry_once();
        test_retry_limit();
        test_saturation();
        test_tmr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
